// File: rtl/avr_seq_ctrl.sv
// avr_seq_ctrl: per-instruction control sequencer between avr_fetch and avr_cpu.
// Decodes the current word, steers the fetch PC (pc_src/jmp), squashes wrong-path
// words after taken flow changes, runs the second word of JMP and the LD/ST-via-X
// data-memory handshake, and gates register-file write-back.
// Optional build macro SEQ_STALL_CNT_EN adds a saturating stall_cnt output that
// counts cycles spent in FLUSH, JMP2 or MEMW.
module avr_seq_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] instr_i,
  input  logic [7:0]  sreg_i,
  input  logic        dmem_ack,
  output logic [2:0]  pc_src,
  output logic [15:0] jmp,
  output logic [15:0] instr_o,
  output logic        wb_en,
  output logic        dmem_req,
  output logic        dmem_we,
`ifdef SEQ_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        mem_err
);

  typedef enum logic [2:0] {
    RESET = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    JMP2  = 3'd3,
    MEMW  = 3'd4
  } state_t;

  localparam logic [2:0] PC_RESET = 3'b000;
  localparam logic [2:0] PC_HOLD  = 3'b001;
  localparam logic [2:0] PC_INC   = 3'b010;
  localparam logic [2:0] PC_REL   = 3'b100;
  localparam logic [2:0] PC_ABS   = 3'b101;
  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt;
  logic [15:0] mem_instr;

  logic is_rjmp, is_br, br_taken, is_jmp, is_ld, is_st, is_alu;

  // Instruction-class decode of the word currently presented by fetch
  always_comb begin
    is_rjmp  = (instr_i[15:12] == 4'b1100);
    is_br    = (instr_i[15:11] == 5'b11110);
    br_taken = instr_i[10] ? ~sreg_i[instr_i[2:0]] : sreg_i[instr_i[2:0]];
    is_jmp   = (instr_i[15:9] == 7'b1001010) && (instr_i[3:1] == 3'b110);
    is_ld    = (instr_i[15:9] == 7'b1001000) && (instr_i[3:0] == 4'b1100);
    is_st    = (instr_i[15:9] == 7'b1001001) && (instr_i[3:0] == 4'b1100);
    // Words that write a register: SBC/ADD, SUB/ADC, AND/EOR/OR/MOV, SBCI/SUBI/ORI/ANDI, LDI
    casez (instr_i[15:10])
      6'b00001?, 6'b00011?, 6'b0010??, 6'b01????, 6'b1110??: is_alu = 1'b1;
      default:                                             is_alu = 1'b0;
    endcase
  end

  // Next-state and output decode; everything defaults to plain sequential execution
  always_comb begin
    state_d  = state_q;
    pc_src   = PC_INC;
    jmp      = 16'h0000;
    instr_o  = instr_i;
    wb_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    mem_err  = 1'b0;
    case (state_q)
      RESET: begin
        pc_src  = PC_RESET;
        instr_o = 16'h0000;
        state_d = RUN;
      end
      RUN: begin
        wb_en = is_alu;
        if (is_rjmp) begin
          pc_src  = PC_REL;
          jmp     = {{4{instr_i[11]}}, instr_i[11:0]};
          state_d = FLUSH;
        end else if (is_br && br_taken) begin
          pc_src  = PC_REL;
          jmp     = {{9{instr_i[9]}}, instr_i[9:3]};
          state_d = FLUSH;
        end else if (is_jmp) begin
          instr_o = 16'h0000;
          state_d = JMP2;
        end else if (is_ld || is_st) begin
          pc_src   = PC_HOLD;
          dmem_req = 1'b1;
          dmem_we  = instr_i[9];
          state_d  = MEMW;
        end
      end
      FLUSH: begin
        instr_o = 16'h0000;
        state_d = RUN;
      end
      JMP2: begin
        pc_src  = PC_ABS;
        jmp     = instr_i;
        instr_o = 16'h0000;
        state_d = FLUSH;
      end
      MEMW: begin
        pc_src   = PC_HOLD;
        instr_o  = mem_instr;
        dmem_req = 1'b1;
        dmem_we  = mem_instr[9];
        if (dmem_ack) begin
          wb_en   = ~mem_instr[9];
          pc_src  = PC_INC;
          state_d = RUN;
        end else if (wait_cnt == TIMEOUT) begin
          mem_err  = 1'b1;
          dmem_req = 1'b0;
          dmem_we  = 1'b0;
          pc_src   = PC_INC;
          state_d  = RUN;
        end
      end
      default: begin
        pc_src  = PC_RESET;
        instr_o = 16'h0000;
        state_d = RESET;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= RESET;
    else        state_q <= state_d;
  end

  // Wait counter runs only while staying in MEMW; latch the memory word on entry
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt  <= 8'd0;
      mem_instr <= 16'h0000;
    end else begin
      if (state_q == MEMW && state_d == MEMW) wait_cnt <= wait_cnt + 8'd1;
      else                                    wait_cnt <= 8'd0;
      if (state_q == RUN && state_d == MEMW)  mem_instr <= instr_i;
    end
  end

`ifdef SEQ_STALL_CNT_EN
  // Saturating count of non-issuing cycles, cleared only by reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stall_cnt <= 16'h0000;
    else if ((state_q == FLUSH || state_q == JMP2 || state_q == MEMW) && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
